xpmwrap_tdpram_port_ctrl: RTL and testbench



---
 rtl/xpmwrap_pkg.sv | 22 ++
 rtl/xpmwrap_tdpram_port_ctrl_if.sv | 34 +++
 rtl/xpmwrap_sync_fifo.sv | 70 +++++++
 rtl/xpmwrap_tdpram_port_ctrl.sv | 126 ++++++++++++
 tb/tb_xpmwrap_tdpram_port_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xpmwrap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xpmwrap_pkg
//  Purpose  : Shared types and constants for the xpmwrap RAM port controller.
//             Holds the response record layout and the default RAM read
//             latency.
//  Revision : 1.0 - initial release
// ============================================================================
package xpmwrap_pkg;

    localparam int XPMWRAP_RAM_LATENCY_DEFAULT = 2;
    localparam int XPMWRAP_DATA_WIDTH          = 32;
    localparam int XPMWRAP_ERR_WIDTH           = 2;

    // One read response: {double-bit error, single-bit error} plus data.
    typedef struct packed {
        logic [XPMWRAP_ERR_WIDTH-1:0]  err;
        logic [XPMWRAP_DATA_WIDTH-1:0] data;
    } xpmwrap_rsp_t;

endpackage
`default_nettype wire

// File: rtl/xpmwrap_tdpram_port_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : xpmwrap_tdpram_port_ctrl_if
//  Purpose  : Request/response handshake bundle between a client engine
//             (master) and the RAM port controller (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface xpmwrap_tdpram_port_ctrl_if
    import xpmwrap_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_we;
    logic [ADDR_WIDTH-1:0]        req_addr;
    logic [DATA_WIDTH-1:0]        req_wdata;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [DATA_WIDTH-1:0]        rsp_rdata;
    logic [XPMWRAP_ERR_WIDTH-1:0] rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/xpmwrap_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : xpmwrap_sync_fifo
//  Purpose  : Single-clock FIFO. Outputs (data, empty, full, count) come
//             only from registered state, so a pushed entry is visible the
//             cycle after the push (no fall-through).
//  Revision : 1.0 - initial release
// ============================================================================
module xpmwrap_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Pointer wrap bit distinguishes full from empty.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state: write the entry at the tail, advance pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + CW'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
        end
    end

    // State register; storage is cleared so the data output is 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Callers size their credits so a push never meets a full buffer.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule
`default_nettype wire

// File: rtl/xpmwrap_tdpram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : xpmwrap_tdpram_port_ctrl
//  Purpose  : Drives one port of xpmwrap_tdpram from a valid/ready request
//             stream and returns read data on a valid/ready response stream.
//             Reads are credit-limited so the response buffer never overflows
//             while the consumer stalls; writes are never throttled.
//  Options  : XPMWRAP_PORT_CTRL_ECC_EN - carry RAM sbiterr/dbiterr through to
//             rsp_err; otherwise rsp_err is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module xpmwrap_tdpram_port_ctrl
    import xpmwrap_pkg::*;
#(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = XPMWRAP_RAM_LATENCY_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clka,
    input  logic                            rsta,
    xpmwrap_tdpram_port_ctrl_if.slave       bus,
    output logic                            ram_ena,
    output logic                            ram_wea,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_din,
    output logic                            ram_regce,
    output logic                            ram_rst,
    input  logic [DATA_WIDTH-1:0]           ram_dout,
    input  logic                            ram_sbiterr,
    input  logic                            ram_dbiterr
);
    localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int          INF_W       = $clog2(READ_LATENCY + 1);
    localparam logic [31:0] DEPTH_LIMIT = FIFO_DEPTH;
`ifdef XPMWRAP_PORT_CTRL_ECC_EN
    localparam int          ENTRY_W     = DATA_WIDTH + XPMWRAP_ERR_WIDTH;
`else
    localparam int          ENTRY_W     = DATA_WIDTH;
`endif

    logic                    req_accept;
    logic                    rd_accept;
    logic                    credit_ok;
    logic                    rsp_pop;
    logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic [INF_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic [ENTRY_W-1:0]      fifo_wdata;
    logic [ENTRY_W-1:0]      fifo_rdata;
    logic                    fifo_empty;
    logic                    fifo_full;

    // A read may only start if its response already has a reserved slot:
    // buffered responses plus reads still inside the RAM pipeline.
    assign credit_ok     = ({{(32-CNT_W){1'b0}}, fifo_count}
                          + {{(32-INF_W){1'b0}}, inflight}) < DEPTH_LIMIT;
    assign bus.req_ready = !rsta && (bus.req_we || credit_ok);
    assign req_accept    = bus.req_valid && bus.req_ready;
    assign rd_accept     = req_accept && !bus.req_we;

    // RAM samples these on the same edge as the handshake.
    assign ram_ena   = req_accept;
    assign ram_wea   = req_accept && bus.req_we;
    assign ram_addr  = bus.req_addr;
    assign ram_din   = bus.req_wdata;
    assign ram_regce = 1'b1;
    assign ram_rst   = rsta;

    // Read-tracking shift register: one bit per outstanding RAM read stage.
    always_comb begin
        rd_pipe_d = READ_LATENCY'({rd_pipe_q, rd_accept});
    end

    // Count reads still inside the RAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + INF_W'(rd_pipe_q[i]);
        end
    end

    // Shift register state; reset drops all outstanding reads.
    always_ff @(posedge clka) begin
        if (rsta) begin
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q <= rd_pipe_d;
        end
    end

`ifdef XPMWRAP_PORT_CTRL_ECC_EN
    assign fifo_wdata  = {ram_dbiterr, ram_sbiterr, ram_dout};
    assign bus.rsp_err = rsta ? '0 : fifo_rdata[ENTRY_W-1 -: XPMWRAP_ERR_WIDTH];
`else
    logic unused_ecc_flags;
    assign unused_ecc_flags = ram_sbiterr ^ ram_dbiterr;
    assign fifo_wdata       = ram_dout;
    assign bus.rsp_err      = '0;
`endif

    // Response path: outputs forced to idle while reset is held.
    assign bus.rsp_valid = !rsta && !fifo_empty;
    assign bus.rsp_rdata = rsta ? '0 : fifo_rdata[DATA_WIDTH-1:0];
    assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;

    xpmwrap_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clka),
        .rst       (rsta),
        .push      (rd_pipe_q[READ_LATENCY-1]),
        .push_data (fifo_wdata),
        .pop       (rsp_pop),
        .pop_data  (fifo_rdata),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_xpmwrap_tdpram_port_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_xpmwrap_tdpram_port_ctrl
//  Purpose  : Directed bench for the RAM port controller with a behavioural
//             2-cycle RAM port and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xpmwrap_tdpram_port_ctrl;
    import xpmwrap_pkg::*;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int LAT = 2;
`ifdef XPMWRAP_PORT_CTRL_ECC_EN
    localparam bit ECC = 1'b1;
`else
    localparam bit ECC = 1'b0;
`endif

    logic clka = 1'b0;
    logic rsta = 1'b1;
    always #5 clka = ~clka;

    xpmwrap_tdpram_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          ram_ena, ram_wea, ram_regce, ram_rst;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic          ram_sbiterr, ram_dbiterr;

    xpmwrap_tdpram_port_ctrl #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (LAT),
        .FIFO_DEPTH   (4)
    ) dut (
        .clka        (clka),
        .rsta        (rsta),
        .bus         (bus),
        .ram_ena     (ram_ena),
        .ram_wea     (ram_wea),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_regce   (ram_regce),
        .ram_rst     (ram_rst),
        .ram_dout    (ram_dout),
        .ram_sbiterr (ram_sbiterr),
        .ram_dbiterr (ram_dbiterr)
    );

    // Behavioural RAM port: read data appears LAT cycles after the accept.
    logic [DW-1:0] ram_mem [64];
    logic [DW-1:0] p1_d, p2_d;
    logic [1:0]    p1_e, p2_e;
    logic [1:0]    inj_err = 2'b00;
    always @(posedge clka) begin
        if (ram_ena && ram_wea) ram_mem[ram_addr] <= ram_din;
        if (ram_rst) begin
            p1_d <= '0; p1_e <= '0; p2_d <= '0; p2_e <= '0;
        end else begin
            p1_d <= ram_mem[ram_addr];
            p1_e <= (ram_ena && !ram_wea) ? inj_err : 2'b00;
            if (ram_regce) begin
                p2_d <= p1_d;
                p2_e <= p1_e;
            end
        end
    end
    assign ram_dout    = p2_d;
    assign ram_sbiterr = p2_e[0];
    assign ram_dbiterr = p2_e[1];

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        xpmwrap_rsp_t rsp;
        int           cyc;
    } sb_t;
    sb_t sb_q [$];
    sb_t mon_e;

    // Monitor: every response handshake pops and compares one expectation.
    always @(negedge clka) begin
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp got=%0h exp=none (cycle %0d)", bus.rsp_rdata, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_data", bus.rsp_rdata, mon_e.rsp.data);
                chk("rsp_err", bus.rsp_err, mon_e.rsp.err);
                if (mon_e.cyc >= 0) chk("rsp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = d;
        @(negedge clka);
        chk("wr_ready", bus.req_ready, 1'b1);
        chk("wr_ena", ram_ena, 1'b1);
        chk("wr_wea", ram_wea, 1'b1);
        chk("wr_addr", ram_addr, a);
        @(posedge clka); #1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0;
    endtask

    // Offer a read until accepted; queue the expected response on accept.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                           input logic [1:0] exp_e, input logic [1:0] inj,
                           input bit timed, input bit track, output int waited);
        sb_t e;
        waited = 0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a; inj_err = inj;
        @(negedge clka);
        while (!bus.req_ready && waited < 40) begin
            @(negedge clka);
            waited++;
        end
        chk("rd_accept", bus.req_ready, 1'b1);
        if (bus.req_ready && track) begin
            e.rsp.data = exp_d;
            e.rsp.err  = exp_e;
            e.cyc      = timed ? cyc + LAT + 1 : -1;
            sb_q.push_back(e);
        end
        @(posedge clka); #1;
        bus.req_valid = 1'b0; inj_err = 2'b00;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clka); #1;
            n++;
        end
        repeat (3) begin @(posedge clka); #1; end
        chk("drain_empty", sb_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 1'b0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        chk({tag, "_rsp_err"},   bus.rsp_err, 2'b00);
        chk({tag, "_ram_ena"},   ram_ena, 1'b0);
        chk({tag, "_ram_wea"},   ram_wea, 1'b0);
        chk({tag, "_ram_rst"},   ram_rst, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = '0;
        bus.req_wdata = 32'h1234_5678; bus.rsp_ready = 1'b1;
        rsta = 1'b1;
        repeat (2) @(posedge clka);
        #1;
        @(negedge clka);
        chk_reset_outputs("init");
        chk("init_regce", ram_regce, 1'b1);
        @(posedge clka); #1;
        rsta = 1'b0; bus.req_valid = 1'b0; bus.req_we = 1'b0;

        // Write then read back with exact latency.
        do_write(6'd5, 32'hDEAD_BEEF);
        do_read(6'd5, 32'hDEAD_BEEF, 2'b00, 2'b00, 1'b1, 1'b1, w);
        drain();

        // Preload 0..7 and read back-to-back.
        for (int i = 0; i < 8; i++) do_write(AW'(i), DW'(i));
        for (int i = 0; i < 8; i++) begin
            do_read(AW'(i), DW'(i), 2'b00, 2'b00, 1'b1, 1'b1, w);
            chk("burst_no_stall", w, 0);
        end
        drain();

        // Read followed by write to the same address returns old data.
        do_read(6'd3, 32'd3, 2'b00, 2'b00, 1'b1, 1'b1, w);
        do_write(6'd3, 32'h33);
        do_read(6'd3, 32'h33, 2'b00, 2'b00, 1'b1, 1'b1, w);
        drain();

        // Consumer stalled: exactly four reads fit.
        bus.rsp_ready = 1'b0;
        do_read(6'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, w); chk("stall_acc0", w, 0);
        do_read(6'd1, 32'd1, 2'b00, 2'b00, 1'b0, 1'b1, w); chk("stall_acc1", w, 0);
        do_read(6'd2, 32'd2, 2'b00, 2'b00, 1'b0, 1'b1, w); chk("stall_acc2", w, 0);
        do_read(6'd4, 32'd4, 2'b00, 2'b00, 1'b0, 1'b1, w); chk("stall_acc3", w, 0);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 6'd6;
        repeat (5) begin
            @(negedge clka);
            chk("stall_full_ready", bus.req_ready, 1'b0);
        end
        @(posedge clka); #1;
        bus.req_valid = 1'b0;
        // Writes bypass the read credits.
        do_write(6'd10, 32'hA5A5_A5A5);
        bus.rsp_ready = 1'b1;
        do_read(6'd6, 32'd6, 2'b00, 2'b00, 1'b0, 1'b1, w);
        chk("credit_return_fast", (w <= 1), 1'b1);
        do_read(6'd7, 32'd7, 2'b00, 2'b00, 1'b0, 1'b1, w);
        drain();

        // Error flag propagation (zero in a build without ECC).
        do_read(6'd10, 32'hA5A5_A5A5, ECC ? 2'b01 : 2'b00, 2'b01, 1'b1, 1'b1, w);
        do_read(6'd4, 32'd4, ECC ? 2'b10 : 2'b00, 2'b10, 1'b1, 1'b1, w);
        drain();

        // Reset with two reads in flight: both are dropped.
        do_read(6'd1, 32'd1, 2'b00, 2'b00, 1'b0, 1'b0, w);
        do_read(6'd2, 32'd2, 2'b00, 2'b00, 1'b0, 1'b0, w);
        rsta = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 6'd0;
        repeat (3) begin
            @(negedge clka);
            chk_reset_outputs("mid");
            @(posedge clka); #1;
        end
        rsta = 1'b0; bus.req_valid = 1'b0;
        @(negedge clka);
        chk("post_reset_ready", bus.req_ready, 1'b1);
        repeat (10) begin @(posedge clka); #1; end

        do_read(6'd5, 32'd5, 2'b00, 2'b00, 1'b1, 1'b1, w);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
